// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Captures ALU result words into a 2-entry FIFO toward the register-file
// writeback port and maintains the architectural status register whose
// carry bit is fed back to the ALU carry input.
// Optional feature macro: ALU_STICKY_FLAGS_EN -- when defined, divideByZero
// (bit 6) and overflow (bit 4) accumulate until clrSticky; when undefined all
// flag bits are overwritten by each flag-updating push and clrSticky is ignored.
module alu_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inResult,
    input  logic [6:0]        inFlags,
    input  logic [RD_W-1:0]   inRd,
    input  logic              inUpdFlags,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outResult,
    output logic [RD_W-1:0]   outRd,
    output logic [6:0]        statusFlags,
    output logic              carryFlag,
    input  logic              clrSticky,
    output logic [1:0]        occupancy
);

    // Storage and pointers
    logic [DATA_W-1:0] r_mem_data [2];
    logic [RD_W-1:0]   r_mem_rd   [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;

    // Registered outputs
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_result;
    logic [RD_W-1:0]   r_out_rd;
    logic [6:0]        r_status;

    // Next-state wires
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_occ_next;
    logic              w_wr_ptr_next;
    logic              w_rd_ptr_next;
    logic [DATA_W-1:0] w_mem_data_next [2];
    logic [RD_W-1:0]   w_mem_rd_next   [2];
    logic [6:0]        w_status_next;

    // Handshakes: inReady depends only on rst and registered occupancy
    assign inReady = !rst && (r_occ != 2'd2);
    assign w_push  = inValid && inReady;
    assign w_pop   = r_out_valid && outReady;

    assign outValid    = r_out_valid;
    assign outResult   = r_out_result;
    assign outRd       = r_out_rd;
    assign statusFlags = r_status;
    assign carryFlag   = r_status[5];
    assign occupancy   = r_occ;

    // Occupancy and pointer next-state
    always_comb begin
        w_occ_next    = r_occ;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
        if (w_push) begin
            w_wr_ptr_next = ~r_wr_ptr;
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_ptr_next = ~r_rd_ptr;
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end
    end

    // Storage next-state: write the pushed entry at the write pointer
    always_comb begin
        w_mem_data_next[0] = r_mem_data[0];
        w_mem_data_next[1] = r_mem_data[1];
        w_mem_rd_next[0]   = r_mem_rd[0];
        w_mem_rd_next[1]   = r_mem_rd[1];
        if (w_push) begin
            w_mem_data_next[r_wr_ptr] = inResult;
            w_mem_rd_next[r_wr_ptr]   = inRd;
        end else begin
            w_mem_data_next[r_wr_ptr] = r_mem_data[r_wr_ptr];
            w_mem_rd_next[r_wr_ptr]   = r_mem_rd[r_wr_ptr];
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [6:0] w_sticky_base;

    // Status next-state: bits 6 and 4 accumulate, set wins over same-cycle clear
    always_comb begin
        w_sticky_base = r_status;
        if (clrSticky) begin
            w_sticky_base[6] = 1'b0;
            w_sticky_base[4] = 1'b0;
        end else begin
            w_sticky_base = r_status;
        end
        if (w_push && inUpdFlags) begin
            w_status_next    = inFlags;
            w_status_next[6] = w_sticky_base[6] | inFlags[6];
            w_status_next[4] = w_sticky_base[4] | inFlags[4];
        end else begin
            w_status_next = w_sticky_base;
        end
    end
`else
    logic w_unused_clr_sticky;
    assign w_unused_clr_sticky = clrSticky;

    // Status next-state: all bits overwritten on a flag-updating push
    always_comb begin
        if (w_push && inUpdFlags) begin
            w_status_next = inFlags;
        end else begin
            w_status_next = r_status;
        end
    end
`endif

    // State and output registers; the head is registered from next-state so
    // a pushed entry reaches the outputs one cycle later, never combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_data[0] <= {DATA_W{1'b0}};
            r_mem_data[1] <= {DATA_W{1'b0}};
            r_mem_rd[0]   <= {RD_W{1'b0}};
            r_mem_rd[1]   <= {RD_W{1'b0}};
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_occ         <= 2'd0;
            r_out_valid   <= 1'b0;
            r_out_result  <= {DATA_W{1'b0}};
            r_out_rd      <= {RD_W{1'b0}};
            r_status      <= 7'b0;
        end else begin
            r_mem_data[0] <= w_mem_data_next[0];
            r_mem_data[1] <= w_mem_data_next[1];
            r_mem_rd[0]   <= w_mem_rd_next[0];
            r_mem_rd[1]   <= w_mem_rd_next[1];
            r_wr_ptr      <= w_wr_ptr_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_occ         <= w_occ_next;
            r_out_valid   <= (w_occ_next != 2'd0);
            r_out_result  <= w_mem_data_next[w_rd_ptr_next];
            r_out_rd      <= w_mem_rd_next[w_rd_ptr_next];
            r_status      <= w_status_next;
        end
    end

endmodule
